// File: rtl/axi_wr_beat_gen_pkg.sv
// Shared types for the AXI write front-end: burst encodings, B response codes, write FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10,
        RSVD  = 2'b11
    } burst_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DATA = 2'b01,
        RESP = 2'b10
    } wr_state_t;

endpackage

// File: rtl/axi_wr_beat_gen_if.sv
// Bundle of the AW/W slave channels, per-beat cache write request and B response.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on every channel; slave = beat generator side, master = upstream/downstream side.
interface axi_wr_beat_gen_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
);
    logic [ADDR_WIDTH-1:0]   in_awaddr;
    logic [ID_WIDTH-1:0]     in_awid;
    logic [1:0]              in_awburst;
    logic [2:0]              in_awsize;
    logic [7:0]              in_awlen;
    logic                    in_awvalid;
    logic                    in_awready;
    logic [DATA_WIDTH-1:0]   in_wdata;
    logic [DATA_WIDTH/8-1:0] in_wstrb;
    logic                    in_wlast;
    logic                    in_wvalid;
    logic                    in_wready;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_data;
    logic [DATA_WIDTH/8-1:0] req_strb;
    logic                    req_last;
    logic                    req_valid;
    logic                    req_ready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport slave (
        input  in_awaddr, in_awid, in_awburst, in_awsize, in_awlen, in_awvalid,
        input  in_wdata, in_wstrb, in_wlast, in_wvalid,
        input  req_ready, bready,
        output in_awready, in_wready,
        output req_addr, req_data, req_strb, req_last, req_valid,
        output bid, bresp, bvalid
    );

    modport master (
        output in_awaddr, in_awid, in_awburst, in_awsize, in_awlen, in_awvalid,
        output in_wdata, in_wstrb, in_wlast, in_wvalid,
        output req_ready, bready,
        input  in_awready, in_wready,
        input  req_addr, req_data, req_strb, req_last, req_valid,
        input  bid, bresp, bvalid
    );
endinterface

// File: rtl/axi_addr_next.sv
// Next-beat byte address for AXI FIXED/INCR/WRAP bursts. Ports: addr_i, size_i, len_i, burst_i -> next_addr_o.
// Latency: purely combinational.
// Backpressure: none.
module axi_addr_next
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [2:0]            size_i,
    input  logic [7:0]            len_i,
    input  burst_t                burst_i,
    output logic [ADDR_WIDTH-1:0] next_addr_o
);
    logic [ADDR_WIDTH-1:0] bytes;
    logic [ADDR_WIDTH-1:0] aligned;
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] wrap_mask;

    always_comb begin
        bytes     = ADDR_WIDTH'(1) << size_i;
        // Only the first beat may be unaligned; every later beat steps from the aligned address.
        aligned   = addr_i & ~(bytes - ADDR_WIDTH'(1));
        incr      = aligned + bytes;
        wrap_mask = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i) - ADDR_WIDTH'(1);
        case (burst_i)
            INCR:    next_addr_o = incr;
            WRAP:    next_addr_o = (aligned & ~wrap_mask) | (incr & wrap_mask);
            default: next_addr_o = addr_i;
        endcase
    end
endmodule

// File: rtl/axi_wr_beat_gen.sv
// AXI write burst to per-beat cache write requests, with B response. Ports: clk, rst, bus (slave modport).
// Latency: zero added latency W -> req (combinational pass-through); B valid the cycle after the last beat.
// Backpressure: W ready follows req_ready; AW stalls outside IDLE; B held until bready; errored bursts drain W.
module axi_wr_beat_gen
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    axi_wr_beat_gen_if.slave  bus
);
    localparam int SIZE_MAX = $clog2(DATA_WIDTH / 8);

    wr_state_t             state_q;
    logic [7:0]            beat_cnt_q;
    logic [7:0]            len_q;
    logic [2:0]            size_q;
    burst_t                burst_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] cur_addr_q;
    logic [ADDR_WIDTH-1:0] cur_addr_d;
    logic                  err_q;
    logic                  awready_q;
    logic                  bvalid_q;
    logic [ID_WIDTH-1:0]   bid_q;
    logic [1:0]            bresp_q;

    logic   in_data;
    logic   w_hs;
    logic   cnt_done;
    logic   early_last;
    logic   cap_err;
    burst_t aw_burst;

    axi_addr_next #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_next (
        .addr_i      (cur_addr_q),
        .size_i      (size_q),
        .len_i       (len_q),
        .burst_i     (burst_q),
        .next_addr_o (cur_addr_d)
    );

    assign aw_burst   = burst_t'(bus.in_awburst);
    assign in_data    = (state_q == DATA);
    assign cnt_done   = (beat_cnt_q == len_q);
    assign early_last = bus.in_wlast & ~cnt_done;
    assign w_hs       = bus.in_wvalid & bus.in_wready;

    // Bursts we cannot address correctly are flagged at capture and their beats are swallowed.
    assign cap_err = (aw_burst == RSVD)
                   | (bus.in_awsize > 3'(SIZE_MAX))
                   | ((aw_burst == WRAP) & !(bus.in_awlen inside {8'd1, 8'd3, 8'd7, 8'd15}));

    // In an errored burst W is drained regardless of the cache so the master is never stuck.
    assign bus.in_wready = in_data & (err_q | bus.req_ready);
    assign bus.req_valid = in_data & ~err_q & bus.in_wvalid;
    assign bus.req_addr  = cur_addr_q;
    assign bus.req_data  = bus.in_wdata;
    assign bus.req_strb  = bus.in_wstrb;
    assign bus.req_last  = in_data & (cnt_done | bus.in_wlast);

    assign bus.in_awready = awready_q;
    assign bus.bvalid     = bvalid_q;
    assign bus.bid        = bid_q;
    assign bus.bresp      = bresp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= FIXED;
            id_q       <= '0;
            cur_addr_q <= '0;
            err_q      <= 1'b0;
            awready_q  <= 1'b1;
            bvalid_q   <= 1'b0;
            bid_q      <= '0;
            bresp_q    <= RESP_OKAY;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_awvalid) begin
                        id_q       <= bus.in_awid;
                        cur_addr_q <= bus.in_awaddr;
                        len_q      <= bus.in_awlen;
                        size_q     <= bus.in_awsize;
                        burst_q    <= aw_burst;
                        beat_cnt_q <= '0;
                        err_q      <= cap_err;
                        awready_q  <= 1'b0;
                        state_q    <= DATA;
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        beat_cnt_q <= beat_cnt_q + 8'd1;
                        cur_addr_q <= cur_addr_d;
                        if (early_last) begin
                            err_q <= 1'b1;
                        end
                        // An early wlast ends the burst; any extra beats belong to nobody here.
                        if (cnt_done | bus.in_wlast) begin
                            state_q  <= RESP;
                            bvalid_q <= 1'b1;
                            bid_q    <= id_q;
                            bresp_q  <= (err_q | early_last) ? RESP_SLVERR : RESP_OKAY;
                        end
                    end
                end
                RESP: begin
                    if (bus.bready) begin
                        bvalid_q  <= 1'b0;
                        err_q     <= 1'b0;
                        awready_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    awready_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi_wr_beat_gen.sv
// Self-checking bench for axi_wr_beat_gen: table of bursts plus hand-written multi-cycle sequences.
// Latency: n/a.
// Backpressure: exercised via req_ready toggling and bready hold.
module tb_axi_wr_beat_gen;
    import axi_pkg::*;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_wr_beat_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    axi_wr_beat_gen #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]       burst;
        logic [31:0]      addr;
        logic [2:0]       size;
        logic [7:0]       len;
        int               wlast_at;
        logic             drop;
        logic [1:0]       resp;
        logic [3:0][31:0] exp_addr;
    } vec_t;

    vec_t vecs [9];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int idx, input logic [1:0] burst, input logic [31:0] addr,
                           input logic [2:0] size, input logic [7:0] len, input int wl,
                           input logic drop, input logic [1:0] resp,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] a2, input logic [31:0] a3);
        vecs[idx].burst       = burst;
        vecs[idx].addr        = addr;
        vecs[idx].size        = size;
        vecs[idx].len         = len;
        vecs[idx].wlast_at    = wl;
        vecs[idx].drop        = drop;
        vecs[idx].resp        = resp;
        vecs[idx].exp_addr[0] = a0;
        vecs[idx].exp_addr[1] = a1;
        vecs[idx].exp_addr[2] = a2;
        vecs[idx].exp_addr[3] = a3;
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic send_aw(input logic [31:0] addr, input logic [3:0] id, input logic [1:0] burst,
                           input logic [2:0] size, input logic [7:0] len);
        bus.in_awaddr  = addr;
        bus.in_awid    = id;
        bus.in_awburst = burst;
        bus.in_awsize  = size;
        bus.in_awlen   = len;
        bus.in_awvalid = 1'b1;
        #1;
        chk("aw_ready_idle", 64'(bus.in_awready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_awvalid = 1'b0;
        #1;
        chk("aw_ready_busy", 64'(bus.in_awready), 64'd0);
    endtask

    task automatic finish_b(input logic [3:0] id, input logic [1:0] resp, input int hold);
        int n = 0;
        while (!bus.bvalid && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("b_valid", 64'(bus.bvalid), 64'd1);
        chk("b_id", 64'(bus.bid), 64'(id));
        chk("b_resp", 64'(bus.bresp), 64'(resp));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            chk("b_hold_valid", 64'(bus.bvalid), 64'd1);
            chk("b_hold_id", 64'(bus.bid), 64'(id));
            chk("b_hold_resp", 64'(bus.bresp), 64'(resp));
        end
        bus.bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.bready = 1'b0;
        #1;
        chk("b_valid_after_hs", 64'(bus.bvalid), 64'd0);
        chk("aw_ready_after_b", 64'(bus.in_awready), 64'd1);
        @(negedge clk);
    endtask

    task automatic run_burst(input vec_t v, input logic [3:0] id);
        logic [63:0] d;
        send_aw(v.addr, id, v.burst, v.size, v.len);
        for (int i = 0; i <= v.wlast_at; i++) begin
            d = {32'hCAFE_0000 | 32'(i), v.addr};
            bus.in_wvalid = 1'b1;
            bus.in_wdata  = d;
            bus.in_wstrb  = 8'hF0 ^ 8'(i);
            bus.in_wlast  = (i == v.wlast_at);
            #1;
            if (v.drop) begin
                chk("drop_req_valid", 64'(bus.req_valid), 64'd0);
                chk("drop_wready", 64'(bus.in_wready), 64'd1);
            end else begin
                chk("req_valid", 64'(bus.req_valid), 64'd1);
                chk("req_addr", 64'(bus.req_addr), 64'(v.exp_addr[i]));
                chk("req_last", 64'(bus.req_last), 64'((i == int'(v.len)) || (i == v.wlast_at)));
                chk("req_data", bus.req_data, d);
                chk("req_strb", 64'(bus.req_strb), 64'(8'hF0 ^ 8'(i)));
            end
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_wvalid = 1'b0;
        bus.in_wlast  = 1'b0;
        finish_b(id, v.resp, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int beat;
        int cyc;
        logic rdy;

        rst            = 1'b1;
        bus.in_awaddr  = '0;
        bus.in_awid    = '0;
        bus.in_awburst = 2'b00;
        bus.in_awsize  = 3'd0;
        bus.in_awlen   = 8'd0;
        bus.in_awvalid = 1'b0;
        bus.in_wdata   = '0;
        bus.in_wstrb   = '0;
        bus.in_wlast   = 1'b0;
        bus.in_wvalid  = 1'b0;
        bus.req_ready  = 1'b1;
        bus.bready     = 1'b0;

        //       idx burst  addr           sz  len wl drop resp   beat addresses
        set_vec(0, 2'b01, 32'h0000_1000, 3, 3, 3, 0, 2'b00, 32'h1000, 32'h1008, 32'h1010, 32'h1018);
        set_vec(1, 2'b10, 32'h0000_1018, 3, 3, 3, 0, 2'b00, 32'h1018, 32'h1000, 32'h1008, 32'h1010);
        set_vec(2, 2'b01, 32'h0000_1000, 3, 3, 1, 0, 2'b10, 32'h1000, 32'h1008, 32'h0,    32'h0);
        set_vec(3, 2'b10, 32'h0000_0104, 2, 1, 1, 0, 2'b00, 32'h0104, 32'h0100, 32'h0,    32'h0);
        set_vec(4, 2'b01, 32'h0000_1003, 2, 2, 2, 0, 2'b00, 32'h1003, 32'h1004, 32'h1008, 32'h0);
        set_vec(5, 2'b10, 32'h0000_0200, 3, 2, 2, 1, 2'b10, 32'h0,    32'h0,    32'h0,    32'h0);
        set_vec(6, 2'b01, 32'h0000_0300, 4, 0, 0, 1, 2'b10, 32'h0,    32'h0,    32'h0,    32'h0);
        set_vec(7, 2'b01, 32'hFFFF_FFF8, 3, 1, 1, 0, 2'b00, 32'hFFFF_FFF8, 32'h0, 32'h0,    32'h0);
        set_vec(8, 2'b00, 32'h0000_2004, 2, 2, 2, 0, 2'b00, 32'h2004, 32'h2004, 32'h2004, 32'h0);

        @(negedge clk);
        #1;
        chk("rst_awready", 64'(bus.in_awready), 64'd1);
        chk("rst_bvalid", 64'(bus.bvalid), 64'd0);
        chk("rst_req_valid", 64'(bus.req_valid), 64'd0);
        chk("rst_wready", 64'(bus.in_wready), 64'd0);
        chk("rst_bid", 64'(bus.bid), 64'd0);
        chk("rst_bresp", 64'(bus.bresp), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 9; k++) begin
            run_burst(vecs[k], 4'(k + 1));
        end

        // FIXED burst with req_ready toggling: W stalls with the cache, data must be held.
        send_aw(32'h0000_2004, 4'h9, 2'b00, 3'd2, 8'd2);
        beat = 0;
        cyc  = 0;
        while (beat < 3 && cyc < 20) begin
            rdy           = (cyc % 2 == 0);
            bus.req_ready = rdy;
            bus.in_wvalid = 1'b1;
            bus.in_wdata  = {32'hF00D_0000 | 32'(beat), 32'h0};
            bus.in_wstrb  = 8'hFF;
            bus.in_wlast  = (beat == 2);
            #1;
            chk("t3_req_valid", 64'(bus.req_valid), 64'd1);
            chk("t3_req_addr", 64'(bus.req_addr), 64'h2004);
            chk("t3_wready", 64'(bus.in_wready), 64'(rdy));
            chk("t3_req_data", bus.req_data, {32'hF00D_0000 | 32'(beat), 32'h0});
            @(posedge clk);
            @(negedge clk);
            if (rdy) beat++;
            cyc++;
        end
        chk("t3_beats", 64'(beat), 64'd3);
        bus.in_wvalid = 1'b0;
        bus.in_wlast  = 1'b0;
        bus.req_ready = 1'b1;
        finish_b(4'h9, 2'b00, 0);

        // Reserved burst type: beats drained silently, SLVERR held while bready is low.
        send_aw(32'h0000_3000, 4'h5, 2'b11, 3'd3, 8'd1);
        for (int i = 0; i < 2; i++) begin
            bus.in_wvalid = 1'b1;
            bus.in_wlast  = (i == 1);
            #1;
            chk("t5_req_valid", 64'(bus.req_valid), 64'd0);
            chk("t5_wready", 64'(bus.in_wready), 64'd1);
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_wvalid = 1'b0;
        bus.in_wlast  = 1'b0;
        finish_b(4'h5, 2'b10, 5);

        // Reset in the middle of a len=7 INCR burst, then a clean burst.
        send_aw(32'h0000_4000, 4'h6, 2'b01, 3'd3, 8'd7);
        for (int i = 0; i < 2; i++) begin
            bus.in_wvalid = 1'b1;
            bus.in_wdata  = 64'(i);
            bus.in_wlast  = 1'b0;
            #1;
            chk("t6_req_addr", 64'(bus.req_addr), 64'(32'h4000 + 32'(i * 8)));
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        chk("t6_pre_rst_valid", 64'(bus.req_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_req_valid", 64'(bus.req_valid), 64'd0);
        chk("t6_rst_bvalid", 64'(bus.bvalid), 64'd0);
        chk("t6_rst_awready", 64'(bus.in_awready), 64'd1);
        chk("t6_rst_wready", 64'(bus.in_wready), 64'd0);
        bus.in_wvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_burst(vecs[0], 4'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
